// File: rtl/spi_transaction_fsm_pkg.sv
// Shared encodings and default widths for the SPI slave transaction controller.
package spi_transaction_fsm_pkg;

    localparam int unsigned WORD_W_DFLT = 8;
    localparam int unsigned ADDR_W_DFLT = 7;
    localparam int unsigned RW_BIT      = 0;
    localparam logic        READ        = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_GET_ADDR = 4'd1,
        ST_GOT_ADDR = 4'd2,
        ST_RD_WAIT  = 4'd3,
        ST_RD_LOAD  = 4'd4,
        ST_RD_OUT   = 4'd5,
        ST_WR_IN    = 4'd6,
        ST_WR_MEM   = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

endpackage

// File: rtl/spi_transaction_fsm_edge_counter.sv
// Saturating SCLK edge counter shared by the address, write and read phases.
module spi_transaction_fsm_edge_counter #(
    parameter int unsigned LIMIT = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic done_c,
    output logic hit_c
);

    logic [CNT_W-1:0] count;

    // Count qualified edges; clear has priority and the count never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count < CNT_W'(LIMIT))) begin
            count <= count + CNT_W'(1);
        end
    end

    // hit_c flags the edge that completes the byte, done_c a full count.
    assign done_c = (count == CNT_W'(LIMIT));
    assign hit_c  = inc && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/spi_transaction_fsm.sv
// Frame-level control for the SPI memory slave: address capture, read load, write commit.
module spi_transaction_fsm
    import spi_transaction_fsm_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DFLT,
    parameter int unsigned ADDR_W = ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              sclk_pos_edge,
    input  logic              sclk_neg_edge,
    input  logic [WORD_W-1:0] sr_pout,
    output logic [ADDR_W-1:0] addr_q,
    output logic              dm_we,
    output logic              sr_pload,
    output logic              miso_en,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    state_t state;
    state_t state_next;
    logic   cnt_clear;
    logic   cnt_inc;
    logic   cnt_done_c;
    logic   cnt_hit_c;
    logic   byte_end;

    spi_transaction_fsm_edge_counter #(
        .LIMIT (WORD_W),
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .done_c  (cnt_done_c),
        .hit_c   (cnt_hit_c)
    );

    assign byte_end = cnt_hit_c || cnt_done_c;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and edge qualification; chip-select release overrides everything.
    always_comb begin
        state_next = state;
        cnt_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!cs_n) state_next = ST_GET_ADDR;
            end
            ST_GET_ADDR: begin
                cnt_inc = sclk_pos_edge;
                if (byte_end) state_next = ST_GOT_ADDR;
            end
            ST_GOT_ADDR: begin
                state_next = (sr_pout[RW_BIT] == READ) ? ST_RD_WAIT : ST_WR_IN;
            end
            ST_RD_WAIT:  state_next = ST_RD_LOAD;
            ST_RD_LOAD:  state_next = ST_RD_OUT;
            ST_RD_OUT: begin
                cnt_inc = sclk_neg_edge;
                if (byte_end) state_next = ST_DONE;
            end
            ST_WR_IN: begin
                cnt_inc = sclk_pos_edge;
                if (byte_end) state_next = ST_WR_MEM;
            end
            ST_WR_MEM:   state_next = ST_DONE;
            ST_DONE:     state_next = ST_DONE;
            default:     state_next = ST_IDLE;
        endcase
        if (cs_n) state_next = ST_IDLE;
        cnt_clear = (state_next != state) || (state == ST_IDLE);
    end

    // Outputs decoded from the next state so each is aligned with the state it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= '0;
            dm_we    <= 1'b0;
            sr_pload <= 1'b0;
            miso_en  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            dm_we    <= (state_next == ST_WR_MEM);
            sr_pload <= (state_next == ST_RD_LOAD);
            miso_en  <= (state_next == ST_RD_OUT);
            busy     <= (state_next != ST_IDLE);
            if ((state == ST_GOT_ADDR) && !cs_n) begin
                addr_q <= ADDR_W'(sr_pout >> 1);
            end
        end
    end

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Bench: frame-level timing model derived from edge timestamps, checked every cycle.
module tb_spi_transaction_fsm;

    localparam int NMAX = 8000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cs_n;
    logic       sclk_pos_edge;
    logic       sclk_neg_edge;
    logic [7:0] sr_pout;
    logic [6:0] addr_q;
    logic       dm_we;
    logic       sr_pload;
    logic       miso_en;
    logic       busy;

    always #5 clk = ~clk;

    spi_transaction_fsm dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cs_n          (cs_n),
        .sclk_pos_edge (sclk_pos_edge),
        .sclk_neg_edge (sclk_neg_edge),
        .sr_pout       (sr_pout),
        .addr_q        (addr_q),
        .dm_we         (dm_we),
        .sr_pload      (sr_pload),
        .miso_en       (miso_en),
        .busy          (busy)
    );

    // Stimulus per cycle and expected outputs per cycle.
    bit         cs_a    [NMAX];
    bit         pos_a   [NMAX];
    bit         neg_a   [NMAX];
    bit         mosi_a  [NMAX];
    logic [7:0] sr_hist [NMAX];
    bit         exp_busy[NMAX];
    bit         exp_we  [NMAX];
    bit         exp_pld [NMAX];
    bit         exp_miso[NMAX];
    bit         addr_ev [NMAX];
    logic [6:0] addr_val[NMAX];
    logic [6:0] exp_addr[NMAX];

    int cur;
    int fs_q[$];
    int fe_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s @%0d: got 0x%0h want 0x%0h", name, k, act, want);
        end
    endtask

    task automatic cyc(input bit c, input bit p, input bit n, input bit m);
        cs_a[cur] = c; pos_a[cur] = p; neg_a[cur] = n; mosi_a[cur] = m;
        cur++;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic low(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // MSB-first byte: idle cycle then a pos pulse carrying the bit.
    task automatic pos_bits(input logic [7:0] b, input int nb);
        for (int i = 0; i < nb; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, b[7-i]);
        end
    endtask

    task automatic neg_n(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic end_frame(input int s);
        fs_q.push_back(s);
        fe_q.push_back(cur - 1);
    endtask

    // Cycle of the n-th pos (or neg) pulse within [lo,hi], -1 if absent.
    function automatic int nth(input bit use_pos, input int lo, input int hi, input int n);
        int c = 0;
        for (int k = lo; k <= hi; k++) begin
            if (use_pos ? pos_a[k] : neg_a[k]) begin
                c++;
                if (c == n) return k;
            end
        end
        return -1;
    endfunction

    // Frame with chip select low over cycles s..e. Outputs lag state inputs by one cycle:
    // counted edges start the cycle after cs_n is first seen low.
    task automatic model_frame(input int s, input int e);
        int a8, g, n8, w8, last;
        for (int k = s + 1; k <= e + 1; k++) exp_busy[k] = 1'b1;
        a8 = nth(1'b1, s + 1, e, 8);
        if (a8 < 0) return;
        g = a8 + 1;
        if (g > e) return;
        addr_ev[g+1]  = 1'b1;
        addr_val[g+1] = sr_hist[g][7:1];
        if (sr_hist[g][0]) begin
            if (g + 1 <= e) exp_pld[g+2] = 1'b1;
            if (g + 2 <= e) begin
                n8   = nth(1'b0, g + 3, e, 8);
                last = (n8 >= 0) ? n8 : e + 1;
                for (int k = g + 3; k <= last; k++) exp_miso[k] = 1'b1;
            end
        end else begin
            w8 = nth(1'b1, g + 1, e, 8);
            if (w8 >= 0) exp_we[w8+1] = 1'b1;
        end
    endtask

    function automatic int sum_of(input int sel, input int lo, input int hi);
        int t = 0;
        for (int k = lo; k <= hi; k++) begin
            case (sel)
                0:       t += int'(exp_we[k]);
                1:       t += int'(exp_pld[k]);
                default: t += int'(exp_miso[k]);
            endcase
        end
        return t;
    endfunction

    initial begin
        int s_wr, s_rd, s_ab, e_ab, s_w2, e_w2, s_r2, e_r2, s5, e5, s;
        logic [7:0] sr;
        logic [6:0] a;
        logic [7:0] rb;

        reset_n = 1'b0; cs_n = 1'b1; sclk_pos_edge = 1'b0; sclk_neg_edge = 1'b0; sr_pout = 8'h00;
        for (int k = 0; k < NMAX; k++) cs_a[k] = 1'b1;
        cur = 0;

        // Directed frames.
        gap(3); s_wr = cur; pos_bits(8'h54, 8); pos_bits(8'hC3, 8); low(4); end_frame(s_wr);
        gap(3); s_rd = cur; pos_bits(8'h55, 8); low(3); neg_n(8); low(3); end_frame(s_rd);
        gap(3); s_ab = cur; pos_bits(8'h54, 5); end_frame(s_ab); e_ab = cur - 1;
        gap(3); s_w2 = cur; pos_bits(8'h10, 8); pos_bits(8'hAA, 8); low(2); end_frame(s_w2); e_w2 = cur - 1;
        gap(2); s_r2 = cur; pos_bits(8'h11, 8); low(3); neg_n(8); low(2); end_frame(s_r2); e_r2 = cur - 1;
        gap(3); s5 = cur; pos_bits(8'h20, 8); pos_bits(8'h77, 7); low(1); end_frame(s5); e5 = cur - 1;
        cyc(1'b1, 1'b1, 1'b0, 1'b1);

        // Random frames with random pulse density, including aborts and coincident edges.
        for (int f = 0; f < 45 && cur < NMAX - 200; f++) begin
            int len;
            for (int i = 0, n = int'($urandom_range(2, 4)); i < n; i++)
                cyc(1'b1, ($urandom % 100) < 30, ($urandom % 100) < 30, 1'($urandom));
            s = cur;
            len = int'($urandom_range(3, 75));
            for (int i = 0; i < len; i++)
                cyc(1'b0, ($urandom % 100) < 40, ($urandom % 100) < 40, 1'($urandom));
            end_frame(s);
        end
        gap(4);

        // Bench-side shift register history, then the model.
        sr = 8'h00;
        for (int k = 0; k < NMAX; k++) begin
            sr_hist[k] = sr;
            if (pos_a[k]) sr = {sr[6:0], mosi_a[k]};
        end
        foreach (fs_q[i]) model_frame(fs_q[i], fe_q[i]);
        a = 7'h00;
        for (int k = 0; k < NMAX; k++) begin
            if (addr_ev[k]) a = addr_val[k];
            exp_addr[k] = a;
        end

        // Hand-computed anchors for the model.
        check("pin_wr_we",      s_wr + 32, 32'(exp_we[s_wr+32]), 1);
        check("pin_wr_we_once", s_wr,      32'(sum_of(0, s_wr, s_wr + 40)), 1);
        check("pin_wr_addr",    s_wr + 33, 32'(exp_addr[s_wr+33]), 32'h2A);
        check("pin_wr_busy_hi", s_wr + 36, 32'(exp_busy[s_wr+36]), 1);
        check("pin_wr_busy_lo", s_wr + 37, 32'(exp_busy[s_wr+37]), 0);
        check("pin_rd_pload",   s_rd + 18, 32'(exp_pld[s_rd+18]), 1);
        check("pin_rd_pl_once", s_rd,      32'(sum_of(1, s_rd, s_rd + 40)), 1);
        check("pin_rd_miso_n",  s_rd,      32'(sum_of(2, s_rd, s_rd + 45)), 16);
        check("pin_rd_miso_1",  s_rd + 19, 32'(exp_miso[s_rd+19]), 1);
        check("pin_ab_busy_hi", e_ab + 1,  32'(exp_busy[e_ab+1]), 1);
        check("pin_ab_busy_lo", e_ab + 2,  32'(exp_busy[e_ab+2]), 0);
        check("pin_ab_addr",    e_ab + 2,  32'(exp_addr[e_ab+2]), 32'h2A);
        check("pin_ab_no_str",  s_ab,      32'(sum_of(0, s_ab, e_ab + 3) + sum_of(1, s_ab, e_ab + 3)), 0);
        check("pin_w2_we_once", s_w2,      32'(sum_of(0, s_w2, e_w2 + 1)), 1);
        check("pin_w2_addr",    e_w2 + 1,  32'(exp_addr[e_w2+1]), 32'h08);
        check("pin_gap_busy",   e_w2 + 2,  32'(exp_busy[e_w2+2]), 0);
        check("pin_r2_pl_once", s_r2,      32'(sum_of(1, s_r2, e_r2 + 1)), 1);
        check("pin_ab5_no_we",  s5,        32'(sum_of(0, s5, e5 + 3)), 0);
        check("pin_ab5_addr",   e5 + 2,    32'(exp_addr[e5+2]), 32'h10);

        // Reset state while reset_n is held low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", -1, 32'(busy), 0);
        check("rst_addr", -1, 32'(addr_q), 0);
        check("rst_strb", -1, 32'({dm_we, sr_pload, miso_en}), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Per-cycle comparison against the model.
        for (int k = 0; k < cur; k++) begin
            @(posedge clk);
            #1;
            check("busy",     k, 32'(busy),     32'(exp_busy[k]));
            check("dm_we",    k, 32'(dm_we),    32'(exp_we[k]));
            check("sr_pload", k, 32'(sr_pload), 32'(exp_pld[k]));
            check("miso_en",  k, 32'(miso_en),  32'(exp_miso[k]));
            check("addr_q",   k, 32'(addr_q),   32'(exp_addr[k]));
            cs_n          = cs_a[k];
            sclk_pos_edge = pos_a[k];
            sclk_neg_edge = neg_a[k];
            sr_pout       = sr_hist[k];
        end

        // Asynchronous reset in the middle of a read data phase.
        cs_n = 1'b1; sclk_pos_edge = 1'b0; sclk_neg_edge = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cs_n = 1'b0;
        rb = 8'h55;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            sclk_pos_edge = 1'b1;
            @(posedge clk); #1;
            sclk_pos_edge = 1'b0;
            sr_pout = {sr_pout[6:0], rb[7-i]};
        end
        repeat (4) @(posedge clk);
        #1;
        check("rd_before_rst_miso", -2, 32'(miso_en), 1);
        check("rd_before_rst_addr", -2, 32'(addr_q), 32'h2A);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_miso", -2, 32'(miso_en), 0);
        check("async_rst_busy", -2, 32'(busy), 0);
        check("async_rst_addr", -2, 32'(addr_q), 0);
        check("async_rst_strb", -2, 32'({dm_we, sr_pload}), 0);
        cs_n = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", -3, 32'(busy), 0);
        check("post_rst_addr", -3, 32'(addr_q), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
